// File: rtl/md5_pkg.sv
// Shared types and sizes for the MD5 candidate search slice.
// Top/unit state encodings live here so the dispatcher and bench agree.
package md5_pkg;
  localparam int DIGEST_W  = 128;
  localparam int CAND_W    = 32;
  localparam int MAX_UNITS = 16;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_FINISH
  } top_state_e;

  typedef enum logic [2:0] {
    U_IDLE,
    U_RST,
    U_START,
    U_RUN,
    U_REQ
  } unit_state_e;
endpackage

// File: rtl/cruncher_dispatch_if.sv
// Host config/status plus the cruncher-array control bus.
// master: the dispatcher; slave: host and cruncher array.
interface cruncher_dispatch_if #(
  parameter int NUNITS = 4
);
  import md5_pkg::*;

  logic                         go;
  logic                         abort;
  logic [CAND_W-1:0]            cand_base;
  logic [CAND_W-1:0]            cand_limit;
  logic [DIGEST_W-1:0]          target;
  logic                         busy;
  logic                         done;
  logic                         found;
  logic [CAND_W-1:0]            found_cand;
  logic [CAND_W-1:0]            checked;
  logic [NUNITS-1:0]            unit_reset;
  logic [NUNITS-1:0]            unit_start;
  logic [CAND_W*NUNITS-1:0]     unit_cand;
  logic [NUNITS-1:0]            unit_done;
  logic [DIGEST_W*NUNITS-1:0]   unit_digest;

  modport master (
    input  go, abort, cand_base, cand_limit, target,
    input  unit_done, unit_digest,
    output busy, done, found, found_cand, checked,
    output unit_reset, unit_start, unit_cand
  );

  modport slave (
    output go, abort, cand_base, cand_limit, target,
    output unit_done, unit_digest,
    input  busy, done, found, found_cand, checked,
    input  unit_reset, unit_start, unit_cand
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts
// at the requester after the last one granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   jw, nxt;
  logic [PW-1:0] idx;
  logic          hit;

  // scan requesters starting at the pointer, wrapping at N
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    nxt   = '0;
    jw    = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      jw = {1'b0, ptr_q} + (PW+1)'(i);
      if (jw >= (PW+1)'(N)) jw = jw - (PW+1)'(N);
      idx = jw[PW-1:0];
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        grant[idx] = 1'b1;
        nxt        = jw + (PW+1)'(1);
        if (nxt >= (PW+1)'(N)) nxt = '0;
      end
    end
    ptr_d = ptr_q;
    if (advance && hit) ptr_d = nxt[PW-1:0];
  end

  // last-grant pointer
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cruncher_dispatch.sv
// Schedules candidates over a pool of MD5 crunchers and
// compares each finished digest against the target.
module cruncher_dispatch
  import md5_pkg::*;
#(
  parameter int NUNITS = 4
) (
  input logic               clk,
  input logic               reset,
  cruncher_dispatch_if.master bus
);
  top_state_e          state_q, state_d;
  logic [CAND_W-1:0]   limit_q, limit_d;
  logic [CAND_W-1:0]   next_q, next_d;
  logic [CAND_W-1:0]   fcand_q, fcand_d;
  logic [CAND_W-1:0]   checked_q, checked_d;
  logic [DIGEST_W-1:0] target_q, target_d;
  logic                issued_q, issued_d;
  logic                done_q, done_d;
  logic                found_q, found_d;

  logic [NUNITS-1:0]   udone_q;
  logic [NUNITS-1:0]   u_idle, u_req, disp, grant;
  logic [DIGEST_W-1:0] g_dig;
  logic [CAND_W-1:0]   g_cand;
  logic                run, fin, any_gnt, match;
  logic                exhausted, leave, taken;

  assign run       = (state_q == T_RUN);
  assign fin       = (state_q == T_FINISH);
  assign any_gnt   = |grant;
  assign match     = any_gnt && (g_dig == target_q);
  assign exhausted = issued_q && (&u_idle);
  assign leave     = bus.abort | match | exhausted;

  rr_arbiter #(.N(NUNITS)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (u_req & {NUNITS{run}}),
    .advance (run),
    .grant   (grant)
  );

  // pick the granted unit's digest and candidate
  always_comb begin
    g_dig  = '0;
    g_cand = '0;
    for (int k = 0; k < NUNITS; k++) begin
      if (grant[k]) begin
        g_dig  = bus.unit_digest[k*DIGEST_W +: DIGEST_W];
        g_cand = bus.unit_cand[k*CAND_W +: CAND_W];
      end
    end
  end

  // lowest-index idle unit gets the next candidate
  always_comb begin
    disp  = '0;
    taken = 1'b0;
    if (run && !issued_q && !leave) begin
      for (int k = 0; k < NUNITS; k++) begin
        if (u_idle[k] && !taken) begin
          disp[k] = 1'b1;
          taken   = 1'b1;
        end
      end
    end
  end

  // top-level search sequencing and result capture
  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    target_d  = target_q;
    next_d    = next_q;
    issued_d  = issued_q;
    done_d    = done_q;
    found_d   = found_q;
    fcand_d   = fcand_q;
    checked_d = checked_q;
    unique case (state_q)
      T_IDLE: begin
        if (bus.go) begin
          state_d   = T_RUN;
          limit_d   = bus.cand_limit;
          target_d  = bus.target;
          next_d    = bus.cand_base;
          issued_d  = bus.cand_base > bus.cand_limit;
          done_d    = 1'b0;
          found_d   = 1'b0;
          checked_d = '0;
        end
      end
      T_RUN: begin
        if (|disp) begin
          next_d = next_q + CAND_W'(1);
          if (next_q == limit_q) issued_d = 1'b1;
        end
        if (any_gnt && (checked_q != '1))
          checked_d = checked_q + CAND_W'(1);
        if (match) begin
          found_d = 1'b1;
          fcand_d = g_cand;
        end
        if (leave) state_d = T_FINISH;
      end
      T_FINISH: begin
        done_d  = 1'b1;
        state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
  end

  // top-level state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= T_IDLE;
      limit_q   <= '0;
      target_q  <= '0;
      next_q    <= '0;
      issued_q  <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      fcand_q   <= '0;
      checked_q <= '0;
      udone_q   <= '0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      target_q  <= target_d;
      next_q    <= next_d;
      issued_q  <= issued_d;
      done_q    <= done_d;
      found_q   <= found_d;
      fcand_q   <= fcand_d;
      checked_q <= checked_d;
      udone_q   <= bus.unit_done;
    end
  end

  for (genvar k = 0; k < NUNITS; k++) begin : g_unit
    unit_state_e       us_q, us_d;
    logic [CAND_W-1:0] cand_q, cand_d;

    // per-unit reset, start, wait, request sequence
    always_comb begin
      us_d   = us_q;
      cand_d = cand_q;
      if (fin) begin
        us_d = U_IDLE;
      end else begin
        unique case (us_q)
          U_IDLE: begin
            if (disp[k]) begin
              us_d   = U_RST;
              cand_d = next_q;
            end
          end
          U_RST:   us_d = U_START;
          U_START: us_d = U_RUN;
          U_RUN:   if (udone_q[k]) us_d = U_REQ;
          U_REQ:   if (grant[k]) us_d = U_IDLE;
          default: us_d = U_IDLE;
        endcase
      end
    end

    // per-unit state and candidate registers
    always_ff @(posedge clk) begin
      if (reset) begin
        us_q   <= U_IDLE;
        cand_q <= '0;
      end else begin
        us_q   <= us_d;
        cand_q <= cand_d;
      end
    end

    assign u_idle[k]         = (us_q == U_IDLE);
    assign u_req[k]          = (us_q == U_REQ);
    assign bus.unit_reset[k] = reset | fin | (us_q == U_RST);
    assign bus.unit_start[k] = (us_q == U_START);
    assign bus.unit_cand[k*CAND_W +: CAND_W] = cand_q;
  end

  assign bus.busy       = (state_q != T_IDLE);
  assign bus.done       = done_q;
  assign bus.found      = found_q;
  assign bus.found_cand = fcand_q;
  assign bus.checked    = checked_q;
endmodule

// File: tb/tb_cruncher_dispatch.sv
// Bench for cruncher_dispatch with stub crunchers:
// digest = {4{cand}}, done L cycles after start.
module tb_cruncher_dispatch;
  import md5_pkg::*;

  localparam int NU = 4;
  localparam int L  = 20;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cruncher_dispatch_if #(.NUNITS(NU)) bus ();

  cruncher_dispatch #(.NUNITS(NU)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // stub crunchers
  logic [NU-1:0] st_run = '0;
  logic [NU-1:0] udone  = '0;
  logic [NU-1:0] ready;
  int            st_cnt [NU];
  logic          hold = 1'b0;
  logic          rel  = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < NU; k++) begin
      if (bus.unit_reset[k]) begin
        st_run[k] <= 1'b0;
        st_cnt[k] <= 0;
        udone[k]  <= 1'b0;
      end else if (bus.unit_start[k]) begin
        st_run[k] <= 1'b1;
        st_cnt[k] <= 0;
      end else if (st_run[k]) begin
        if (st_cnt[k] < L) st_cnt[k] <= st_cnt[k] + 1;
        if (st_cnt[k] >= L - 1 && (!hold || rel)) udone[k] <= 1'b1;
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int k = 0; k < NU; k++)
      ready[k] = st_run[k] && (st_cnt[k] >= L - 1);
  end

  assign bus.unit_done = udone;
  for (genvar k = 0; k < NU; k++) begin : g_stub
    assign bus.unit_digest[k*128 +: 128] = {4{bus.unit_cand[k*32 +: 32]}};
  end

  // search model: candidates must start in order base..limit,
  // found iff target word lies in range
  logic        mon_on = 1'b0;
  logic [32:0] exp_next = '0;
  logic [31:0] exp_lim  = '0;
  logic        exp_found = 1'b0;
  logic [31:0] exp_cand = '0;
  int          n_starts = 0;
  logic [31:0] first4 [4];
  logic [31:0] mon_c;

  always @(negedge clk) begin
    if (mon_on && !reset) begin
      for (int k = 0; k < NU; k++) begin
        if (bus.unit_start[k]) begin
          mon_c = bus.unit_cand[k*32 +: 32];
          chk("dispatch_order", 128'({1'b0, mon_c}), 128'(exp_next));
          chk("dispatch_in_range", 128'(mon_c <= exp_lim), 128'(1));
          if (n_starts < 4) first4[n_starts] = mon_c;
          exp_next++;
          n_starts++;
        end
      end
      chk("checked_le_starts", 128'(bus.checked <= 32'(n_starts)),
          128'(1));
      if (bus.done) begin
        chk("found", 128'(bus.found), 128'(exp_found));
        if (exp_found)
          chk("found_cand", 128'(bus.found_cand), 128'(exp_cand));
      end
    end
  end

  task automatic do_reset;
    mon_on = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",       128'(bus.busy),       128'(0));
    chk("rst_done",       128'(bus.done),       128'(0));
    chk("rst_found",      128'(bus.found),      128'(0));
    chk("rst_found_cand", 128'(bus.found_cand), 128'(0));
    chk("rst_checked",    128'(bus.checked),    128'(0));
    chk("rst_unit_start", 128'(bus.unit_start), 128'(0));
    chk("rst_unit_cand",  128'(bus.unit_cand),  128'(0));
    chk("rst_unit_reset", 128'(bus.unit_reset), 128'(4'hF));
    reset = 1'b0;
  endtask

  task automatic start_search(input logic [31:0] b, input logic [31:0] lim,
                              input logic [31:0] t);
    @(negedge clk);
    bus.cand_base  = b;
    bus.cand_limit = lim;
    bus.target     = {4{t}};
    bus.go         = 1'b1;
    @(posedge clk);
    #1;
    bus.go    = 1'b0;
    exp_next  = {1'b0, b};
    exp_lim   = lim;
    n_starts  = 0;
    exp_found = (b <= lim) && (t >= b) && (t <= lim);
    exp_cand  = t;
    mon_on    = 1'b1;
    chk("busy_after_go", 128'(bus.busy), 128'(1));
    chk("done_cleared",  128'(bus.done), 128'(0));
  endtask

  task automatic wait_done(input int maxc, output int nc,
                           output logic [3:0] last_rst);
    nc       = 0;
    last_rst = '0;
    forever begin
      @(negedge clk);
      nc++;
      if (bus.done) break;
      last_rst = bus.unit_reset;
      if (nc >= maxc) break;
    end
    chk("done_seen", 128'(bus.done), 128'(1));
    chk("busy_at_done", 128'(bus.busy), 128'(0));
  endtask

  int         nc;
  logic [3:0] lr;
  logic [3:0] g [4];

  initial begin
    bus.go         = 1'b0;
    bus.abort      = 1'b0;
    bus.cand_base  = '0;
    bus.cand_limit = '0;
    bus.target     = '0;
    do_reset();

    // match inside a 16-candidate range
    start_search(32'h10, 32'h1F, 32'h17);
    wait_done(2000, nc, lr);
    chk("t1_found",      128'(bus.found),      128'(1));
    chk("t1_found_cand", 128'(bus.found_cand), 128'(32'h17));
    for (int i = 0; i < 4; i++)
      chk("t1_first_starts", 128'(first4[i]), 128'(32'h10 + i));
    chk("t1_finish_reset", 128'(lr), 128'(4'hF));

    // exhaustive, no match
    start_search(32'h0, 32'h7, 32'hFF);
    wait_done(2000, nc, lr);
    chk("t2_found",   128'(bus.found),   128'(0));
    chk("t2_checked", 128'(bus.checked), 128'(8));
    chk("t2_starts",  128'(n_starts),    128'(8));

    // top of the candidate space, must not wrap
    start_search(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h5);
    wait_done(2000, nc, lr);
    chk("t3_checked", 128'(bus.checked), 128'(2));
    chk("t3_starts",  128'(n_starts),    128'(2));
    repeat (5) @(negedge clk);
    chk("t3_no_restart", 128'(bus.busy), 128'(0));

    // empty range
    start_search(32'h5, 32'h4, 32'h5);
    wait_done(10, nc, lr);
    chk("t4_latency", 128'(nc <= 3), 128'(1));
    chk("t4_checked", 128'(bus.checked), 128'(0));
    chk("t4_starts",  128'(n_starts),    128'(0));
    chk("t4_reset",   128'(lr),          128'(4'hF));

    // all four finish together
    hold = 1'b1;
    rel  = 1'b0;
    start_search(32'h0, 32'h3, 32'h99);
    nc = 0;
    while (ready != 4'hF && nc < 200) begin
      @(negedge clk);
      nc++;
    end
    chk("t5_all_ready", 128'(ready), 128'(4'hF));
    rel = 1'b1;
    nc  = 0;
    while (dut.u_arb.grant == '0 && nc < 20) begin
      @(negedge clk);
      nc++;
    end
    for (int i = 0; i < 4; i++) begin
      g[i] = dut.u_arb.grant;
      chk("t5_grant_onehot", 128'($onehot(g[i])), 128'(1));
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++)
      chk("t5_grant_rotate", 128'(g[i+1]), 128'({g[i][2:0], g[i][3]}));
    wait_done(100, nc, lr);
    chk("t5_checked", 128'(bus.checked), 128'(4));
    hold = 1'b0;
    rel  = 1'b0;

    // abort mid-search
    start_search(32'h100, 32'h1FF, 32'h5);
    repeat (30) @(negedge clk);
    chk("t6_busy", 128'(bus.busy), 128'(1));
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    wait_done(20, nc, lr);
    chk("t6_found", 128'(bus.found), 128'(0));
    chk("t6_reset", 128'(lr),        128'(4'hF));

    // go ignored while running, then reset mid-search
    start_search(32'h200, 32'h2FF, 32'h5);
    repeat (10) @(negedge clk);
    bus.cand_base = 32'h0;
    bus.go        = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    repeat (30) @(negedge clk);
    chk("t7_busy", 128'(bus.busy), 128'(1));
    do_reset();
    start_search(32'h20, 32'h23, 32'h22);
    wait_done(2000, nc, lr);
    chk("t7_found",      128'(bus.found),      128'(1));
    chk("t7_found_cand", 128'(bus.found_cand), 128'(32'h22));

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_fail);
    $finish;
  end
endmodule
